// File: rtl/aes_round_ctrl.sv
// Purpose : AES-256 round sequencer that owns the state register and steers the state input mux.
// Latency : a block accepted at edge k leaves ROUND after 15 round cycles, so out_valid is high from edge k+15 and the handshake edge is k+16 at the earliest.
// Backpr. : in_ready only in IDLE; out_valid and state_q hold in DONE until out_ready.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; datain is captured only on the accept edge
//   datain              plaintext block
//   rnd_data            result of the external combinational round logic
//   mux_sel             0 = state register loads datain, 1 = loads rnd_data
//   state_q             state register, feeds the round logic
//   round_idx           current round 0..NUM_ROUNDS, selects the round key
//   last_round          high while the final round (no MixColumns) is being computed
//   busy                high in ROUND and DONE
//   out_valid/out_ready output handshake; state_q carries the ciphertext
//   abort               present only when AES_CTRL_ABORT_EN is defined
//
// Build option: define AES_CTRL_ABORT_EN to add the abort port. Without it,
// only rst_n can stop an operation in progress.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 14,
  parameter int DATA_W     = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] rnd_data,
  output logic              mux_sel,
  output logic [DATA_W-1:0] state_q,
  output logic [3:0]        round_idx,
  output logic              last_round,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready
`ifdef AES_CTRL_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  logic   abort_act;
  logic   clr;

`ifdef AES_CTRL_ABORT_EN
  assign abort_act = abort;
`else
  assign abort_act = 1'b0;
`endif

  // Return to IDLE with cleared state: on abort while an operation is in
  // flight, or if the state register ever holds the unused encoding.
  always_comb begin
    clr = 1'b0;
    case (state)
      IDLE:          clr = 1'b0;
      ROUND, DONE:   clr = abort_act;
      default:       clr = 1'b1;
    endcase
  end

  // All outputs are flops updated together with the FSM state, so each one
  // always matches the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      state_q    <= '0;
      round_idx  <= '0;
      mux_sel    <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      last_round <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      state_q    <= '0;
      round_idx  <= '0;
      mux_sel    <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      last_round <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state      <= ROUND;
            state_q    <= datain;
            round_idx  <= '0;
            in_ready   <= 1'b0;
            mux_sel    <= 1'b1;
            busy       <= 1'b1;
            last_round <= (LAST_IDX == 4'd0);
          end
        end
        ROUND: begin
          state_q <= rnd_data;
          if (round_idx == LAST_IDX) begin
            // round_idx stays at the last value through DONE.
            state      <= DONE;
            mux_sel    <= 1'b0;
            last_round <= 1'b0;
            out_valid  <= 1'b1;
          end else begin
            round_idx  <= round_idx + 4'd1;
            last_round <= ((round_idx + 4'd1) == LAST_IDX);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            round_idx <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Purpose : self-checking bench for aes_round_ctrl with an AES-256 round model on rnd_data.
// Latency : n/a (bench).
// Backpr. : drives out_ready both held low and randomised.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] datain = '0;
  logic         in_ready, mux_sel, last_round, busy, out_valid;
  logic [127:0] rnd_data, state_q;
  logic [3:0]   round_idx;
`ifdef AES_CTRL_ABORT_EN
  logic         abort = 1'b0;
`endif

  logic [127:0] rk [0:14];
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(14), .DATA_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .datain(datain), .rnd_data(rnd_data), .mux_sel(mux_sel), .state_q(state_q),
    .round_idx(round_idx), .last_round(last_round), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef AES_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, t, s;
    logic [7:0] e;
    e = 8'hfe;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, a);
    end
    s = r ^ 8'h63;
    t = r;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      s = s ^ t;
    end
    return s;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One AES round r on state s with round key k (0 = AddRoundKey only, 14 = no MixColumns).
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input int r);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [127:0] o;
    if (r == 0) return s ^ k;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        t[rr + 4*c] = b[rr + 4*((c + rr) % 4)];
    if (r != 14) begin
      for (int c = 0; c < 4; c++) begin
        b[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
        b[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
        b[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
        b[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
      end
    end else begin
      for (int i = 0; i < 16; i++) b[i] = t[i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  // Whole-block AES-256 encryption: what the consumer must eventually see.
  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt;
    for (int r = 0; r <= 14; r++) s = aes_round(s, rk[r], r);
    return s;
  endfunction

  // External combinational round logic driven by the controller.
  assign rnd_data = aes_round(state_q, rk[round_idx], int'(round_idx));

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       iv, ordy;
    logic       e_ir, e_mux, mux_chk, e_busy, e_ov, e_last;
    logic [3:0] e_idx;
    logic       ct_chk;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic ordy, input logic ir, input logic mux,
                              input logic mchk, input logic bsy, input logic ov, input logic last,
                              input logic [3:0] idx, input logic ct);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.e_ir = ir; v.e_mux = mux; v.mux_chk = mchk;
    v.e_busy = bsy; v.e_ov = ov; v.e_last = last; v.e_idx = idx; v.ct_chk = ct;
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [29];
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [127:0] q [$];
    logic [127:0] pst;
    logic pov, acc, hs, seen;
    int e, a0, h0, a1;

    // Key schedule for the FIPS-197 C.3 key.
    for (int i = 0; i < 8; i++) w[i] = KEY[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    // Cycle table: inputs for each cycle and the outputs expected after its edge.
    tbl[0] = mk(0, 0, 1, 0, 1, 0, 0, 0, 4'd0, 0);
    tbl[1] = mk(1, 0, 0, 1, 1, 1, 0, 0, 4'd0, 0);
    for (int i = 2; i <= 15; i++) tbl[i] = mk(0, 0, 0, 1, 1, 1, 0, (i == 15), 4'(i - 1), 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 1, 0, 4'd14, 1);
    for (int i = 17; i <= 26; i++) tbl[i] = mk(1, 0, 0, 0, 0, 1, 1, 0, 4'd14, 1);
    tbl[27] = mk(1, 1, 1, 0, 1, 0, 0, 0, 4'd0, 0);
    tbl[28] = mk(0, 0, 1, 0, 1, 0, 0, 0, 4'd0, 0);

    // Asynchronous reset with no clock edge yet.
    #1 rst_n = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset mux_sel", mux_sel, 0);
    chk("reset last_round", last_round, 0);
    chk("reset round_idx", round_idx, 0);
    chk("reset state_q", state_q, 0);
    @(negedge clk) rst_n = 1'b1;

    // Table: FIPS block, sequencing, 10 cycles of back-pressure, ignored in_valid in DONE.
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      datain    = (i <= 1) ? PT : rnd128();
      @(posedge clk);
      #1;
      chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].e_ir);
      if (tbl[i].mux_chk) chk($sformatf("row%0d mux_sel", i), mux_sel, tbl[i].e_mux);
      chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("row%0d out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("row%0d last_round", i), last_round, tbl[i].e_last);
      chk($sformatf("row%0d round_idx", i), round_idx, tbl[i].e_idx);
      if (tbl[i].ct_chk) chk($sformatf("row%0d ciphertext", i), state_q, CT);
    end

    // Overlap: in_valid held high; second accept exactly one edge after the first handshake.
    e = 0; a0 = -1; h0 = -1; a1 = -1;
    for (int n = 0; n < 80 && a1 < 0; n++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      datain    = (a0 < 0) ? PT : rnd128();
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs && h0 < 0) begin
        chk("overlap ciphertext", state_q, CT);
        h0 = e;
      end
      if (acc) begin
        if (a0 < 0) a0 = e;
        else a1 = e;
      end
      e++;
    end
    chk("overlap latency", 128'(h0 - a0), 128'(16));
    chk("overlap restart", 128'(a1 - h0), 128'(1));
    @(negedge clk) in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
    end
    chk("overlap drain", in_ready, 1);

    // Reset mid-operation at round 7.
    in_valid = 1'b1; datain = PT; out_ready = 1'b0;
    @(negedge clk) in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (busy && round_idx == 4'd7) seen = 1'b1;
    end
    chk("midrst reached round 7", round_idx, 7);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst mux_sel", mux_sel, 0);
    chk("midrst last_round", last_round, 0);
    chk("midrst round_idx", round_idx, 0);
    chk("midrst state_q", state_q, 0);
    @(negedge clk) rst_n = 1'b1;
    in_valid = 1'b1; datain = PT; out_ready = 1'b1;
    @(negedge clk) in_valid = 1'b0; datain = rnd128();
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst next out_valid", out_valid, 1);
    chk("midrst next ciphertext", state_q, CT);
    @(negedge clk) out_ready = 1'b0;

`ifdef AES_CTRL_ABORT_EN
    // Abort at round 3, then abort together with out_ready in DONE.
    in_valid = 1'b1; datain = PT;
    @(negedge clk) in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (busy && round_idx == 4'd3) seen = 1'b1;
    end
    chk("abort reached round 3", round_idx, 3);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort in_ready", in_ready, 1);
    chk("abort busy", busy, 0);
    chk("abort round_idx", round_idx, 0);
    chk("abort state_q", state_q, 0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("abort no out_valid", out_valid, 0);
    end
    in_valid = 1'b1; datain = PT;
    @(negedge clk) in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort2 out_valid", out_valid, 1);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0; out_ready = 1'b0;
    chk("abort2 out_valid cleared", out_valid, 0);
    chk("abort2 state_q cleared", state_q, 0);
    chk("abort2 in_ready", in_ready, 1);
`endif

    // Random traffic against a transaction-level AES-256 model.
    pov = 1'b0;
    pst = '0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (pov) begin
        chk("rand hold out_valid", out_valid, 1);
        chk("rand hold state_q", state_q, pst);
      end
      chk("rand in_ready vs busy", in_ready, !busy);
      chk("rand last_round", last_round, mux_sel && round_idx == 4'd14);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      datain    = rnd128();
      if (in_valid && in_ready) q.push_back(enc(datain));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand spurious output", out_valid, 0);
        else chk("rand ciphertext", state_q, q.pop_front());
      end
      pov = out_valid && !out_ready;
      pst = state_q;
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (out_valid) begin
        if (q.size() == 0) chk("rand spurious output", out_valid, 0);
        else chk("rand ciphertext", state_q, q.pop_front());
      end
    end
    chk("rand drained", 128'(q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
